product_accumulator: RTL

//  Downstream consumer of booth_multiplier_16 that accumulates a stream of signed 32-bit products into a

---
 rtl/product_accumulator_pkg.sv | 16 +
 rtl/sat_add_signed.sv | 27 ++
 rtl/product_accumulator.sv | 121 ++++++++++++
 3 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared widths, FSM state type and accumulator limits for the product accumulator.
package product_accumulator_pkg;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int CNT_W  = 8;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/sat_add_signed.sv
// Combinational signed add of a narrow term into a wider accumulator, clamped to the
// accumulator range; clamp flags that the true sum fell outside it.
module sat_add_signed #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  addend,
  output logic [ACC_W-1:0] sum,
  output logic             clamp
);

  logic [ACC_W:0] wide;

  assign wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){addend[IN_W-1]}}, addend};

  // Top two bits differ only when the exact sum no longer fits in ACC_W bits.
  assign clamp = wide[ACC_W] ^ wide[ACC_W-1];

  always_comb begin
    sum = wide[ACC_W-1:0];
    if (clamp) begin
      sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a packet of signed products into a saturating sum and presents the sum,
// term count and overflow flag on a valid/ready result port.
module product_accumulator #(
  parameter int PROD_W = product_accumulator_pkg::PROD_W,
  parameter int ACC_W  = product_accumulator_pkg::ACC_W,
  parameter int CNT_W  = product_accumulator_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  import product_accumulator_pkg::*;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             out_valid_reg, out_valid_next;
  logic [ACC_W-1:0] out_acc_reg, out_acc_next;
  logic [CNT_W-1:0] out_count_reg, out_count_next;
  logic             out_ovf_reg, out_ovf_next;

  logic [ACC_W-1:0] sum;
  logic             clamp;
  logic [CNT_W-1:0] count_inc;

  sat_add_signed #(
    .IN_W  (PROD_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc    (acc_reg),
    .addend (in_product),
    .sum    (sum),
    .clamp  (clamp)
  );

  assign count_inc = (count_reg == {CNT_W{1'b1}}) ? count_reg : count_reg + CNT_W'(1);
  assign in_ready  = (state_reg == ACC) && !clear;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    count_next     = count_reg;
    ovf_next       = ovf_reg;
    out_valid_next = out_valid_reg;
    out_acc_next   = out_acc_reg;
    out_count_next = out_count_reg;
    out_ovf_next   = out_ovf_reg;
    case (state_reg)
      ACC: begin
        if (clear) begin
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
        end else if (in_valid) begin
          if (in_last) begin
            // Result registers capture the sum including this beat; the
            // running state restarts for the next packet.
            out_valid_next = 1'b1;
            out_acc_next   = sum;
            out_count_next = count_inc;
            out_ovf_next   = ovf_reg | clamp;
            acc_next       = '0;
            count_next     = '0;
            ovf_next       = 1'b0;
            state_next     = HOLD;
          end else begin
            acc_next   = sum;
            count_next = count_inc;
            ovf_next   = ovf_reg | clamp;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ACC;
        end
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ACC;
      acc_reg       <= '0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_acc_reg   <= '0;
      out_count_reg <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      ovf_reg       <= ovf_next;
      out_valid_reg <= out_valid_next;
      out_acc_reg   <= out_acc_next;
      out_count_reg <= out_count_next;
      out_ovf_reg   <= out_ovf_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_acc   = out_acc_reg;
  assign out_count = out_count_reg;
  assign out_ovf   = out_ovf_reg;

endmodule
